fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the next-generation pipelined RISC-V core. It replaces the bare PC register and IF/ID latch with a PC generator, a DEPTH-entry first-word-fall-through prefetch queue, and a valid/ready handshake toward ID. It adds back-pressure (ID stall), a one-cycle branch/jump redirect with queue flush, and discard of in-flight responses. It sits between the registered instruction ROM (one-cycle read latency) and the ID stage.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_prefetch_unit_if.sv | 27 ++
 rtl/fetch_prefetch_unit_fwft_fifo.sv | 79 +++++++
 rtl/fetch_prefetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The pc_t/fetch_entry_t typedefs describe the default 32-bit / 10-bit-address configuration.
package fetch_pkg;

  localparam int FETCH_DATA_SIZE = 32;
  localparam int FETCH_ADDR_SIZE = 10;
  localparam int PC_STEP         = 4;

  typedef logic [FETCH_ADDR_SIZE+1:0] pc_t;

  typedef struct packed {
    logic [FETCH_DATA_SIZE-1:0] inst;
    pc_t                        pc;
  } fetch_entry_t;

  // Byte PC to ROM word address
  function automatic logic [FETCH_ADDR_SIZE-1:0] pc_to_word(input pc_t pc);
    return pc[FETCH_ADDR_SIZE+1:2];
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// ROM request/response bus and valid/ready instruction stream toward ID.
// master = fetch unit, slave = ROM + ID side.
interface fetch_prefetch_unit_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10
);

  logic [DATA_SIZE-1:0] idata;
  logic [ADDR_SIZE-1:0] iaddr;
  logic                 ireq;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [DATA_SIZE-1:0] inst;
  logic [ADDR_SIZE+1:0] inst_pc;
  logic [ADDR_SIZE+1:0] inst_pc_plus4;

  modport master (
    input  idata, inst_ready,
    output iaddr, ireq, inst_valid, inst, inst_pc, inst_pc_plus4
  );

  modport slave (
    output idata, inst_ready,
    input  iaddr, ireq, inst_valid, inst, inst_pc, inst_pc_plus4
  );

endinterface

// File: rtl/fetch_prefetch_unit_fwft_fifo.sv
// First-word-fall-through FIFO with synchronous clear; head is readable combinationally.
// Storage resets to zero so the head reads as zero out of reset.
module fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
  assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_clear;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: PC generator, one outstanding ROM read, prefetch queue toward ID.
// Redirect/CLEAR flush the queue, drop the in-flight response and issue the target in the same cycle.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                 DATA_SIZE = FETCH_DATA_SIZE,
  parameter int                 ADDR_SIZE = FETCH_ADDR_SIZE,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_SIZE+1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       CLEAR,
  input  logic                       redirect,
  input  logic [ADDR_SIZE+1:0]       redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  fetch_prefetch_unit_if.master      fbus
);

  localparam int PC_W  = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [PC_W-1:0] upc_t;
  typedef struct packed {
    logic [DATA_SIZE-1:0] inst;
    upc_t                 pc;
  } uentry_t;

  upc_t             r_fetch_pc;
  upc_t             r_pending_pc;
  logic             r_pending;
  logic             w_flush;
  logic             w_can_issue;
  logic             w_ireq;
  logic [CNT_W:0]   w_occupancy;
  upc_t             w_redirect_pc;
  upc_t             w_issue_pc;
  upc_t             w_next_pc;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  uentry_t          w_push_entry;
  uentry_t          w_head;

  // A slot is reserved for the in-flight response, so the queue can never overflow
  assign w_occupancy   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_pending};
  assign w_can_issue   = (w_occupancy < (CNT_W+1)'(DEPTH));
  assign w_flush       = CLEAR | redirect;
  assign w_ireq        = w_can_issue | w_flush;
  assign w_redirect_pc = redirect_pc & ~upc_t'(3);
  assign w_next_pc     = w_issue_pc + upc_t'(PC_STEP);

  // Issue address priority: CLEAR, then redirect, then sequential
  always_comb begin
    w_issue_pc = r_fetch_pc;
    if (CLEAR) begin
      w_issue_pc = RESET_PC;
    end else if (redirect) begin
      w_issue_pc = w_redirect_pc;
    end else begin
      w_issue_pc = r_fetch_pc;
    end
  end

  // PC generator and in-flight request tracking
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fetch_pc   <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
    end else begin
      r_pending <= w_ireq;
      if (w_ireq) begin
        r_pending_pc <= w_issue_pc;
        r_fetch_pc   <= w_next_pc;
      end
    end
  end

  assign w_push       = r_pending & ~w_flush;
  assign w_pop        = ~w_empty & fbus.inst_ready & ~w_flush;
  assign w_push_entry = '{inst: fbus.idata, pc: r_pending_pc};

  fwft_fifo #(
    .WIDTH ($bits(uentry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_clear (w_flush),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign fbus.ireq       = w_ireq;
  assign fbus.iaddr      = w_issue_pc[PC_W-1:2];
  assign fbus.inst_valid = ~w_empty;
  assign fbus.inst       = w_head.inst;
  assign fbus.inst_pc    = w_head.pc;
  assign count           = w_count;

  // pc+4 is forced to zero while empty so it also reads zero out of reset
  always_comb begin
    fbus.inst_pc_plus4 = '0;
    if (!w_empty) begin
      fbus.inst_pc_plus4 = w_head.pc + upc_t'(PC_STEP);
    end else begin
      fbus.inst_pc_plus4 = '0;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a registered ROM returning word n = n.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  logic       CLK;
  logic       RESET_N;
  logic       CLEAR;
  logic       redirect;
  pc_t        redirect_pc;
  logic [2:0] count;

  int   n_checks;
  int   n_fail;
  pc_t  exp_pc;
  int   n_pops;
  logic rdy;

  fetch_prefetch_unit_if #(.DATA_SIZE(32), .ADDR_SIZE(10)) bus ();

  fetch_prefetch_unit #(
    .DATA_SIZE (32),
    .ADDR_SIZE (10),
    .DEPTH     (4),
    .RESET_PC  (12'h000)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .CLEAR       (CLEAR),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count),
    .fbus        (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    bus.idata <= 32'(bus.iaddr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check_head(input string tag, input logic [11:0] pc);
    check({tag, ".valid"}, 64'(bus.inst_valid), 64'd1);
    check({tag, ".pc"}, 64'(bus.inst_pc), 64'(pc));
    check({tag, ".inst"}, 64'(bus.inst), 64'(pc[11:2]));
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    n_pops         = 0;
    RESET_N        = 1'b0;
    CLEAR          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 12'h000;
    bus.inst_ready = 1'b1;
    step();
    step();

    // Reset values
    check("rst.valid", 64'(bus.inst_valid), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.inst", 64'(bus.inst), 64'd0);
    check("rst.pc", 64'(bus.inst_pc), 64'd0);
    check("rst.pc4", 64'(bus.inst_pc_plus4), 64'd0);
    check("rst.iaddr", 64'(bus.iaddr), 64'd0);

    // Stream after reset: valid after the second edge, one per cycle
    RESET_N = 1'b1;
    step();
    check("boot.valid_e1", 64'(bus.inst_valid), 64'd0);
    step();
    check("boot.pc4", 64'(bus.inst_pc_plus4), 64'h4);
    for (int k = 0; k < 6; k++) begin
      check_head("seq", 12'(4 * k));
      step();
    end

    // Stall: queue fills, ireq drops, head stays at pc 0
    CLEAR          = 1'b1;
    bus.inst_ready = 1'b0;
    step();
    CLEAR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.inst_valid) begin
        check("stall.head", 64'(bus.inst_pc), 64'h0);
      end
    end
    check("stall.count", 64'(count), 64'd4);
    check("stall.ireq", 64'(bus.ireq), 64'd0);
    check_head("stall.hd", 12'h000);
    bus.inst_ready = 1'b1;
    step();
    check("stall.ireq_back", 64'(bus.ireq), 64'd1);
    for (int j = 1; j < 6; j++) begin
      check_head("release", 12'(4 * j));
      step();
    end

    // Redirect with three entries queued and one in flight
    CLEAR          = 1'b1;
    bus.inst_ready = 1'b0;
    step();
    CLEAR = 1'b0;
    step();
    step();
    step();
    check("redir.count_pre", 64'(count), 64'd3);
    check("redir.ireq_pre", 64'(bus.ireq), 64'd0);
    redirect       = 1'b1;
    redirect_pc    = 12'h040;
    bus.inst_ready = 1'b1;
    #1;
    check("redir.ireq", 64'(bus.ireq), 64'd1);
    check("redir.iaddr", 64'(bus.iaddr), 64'h10);
    step();
    redirect = 1'b0;
    check("redir.count", 64'(count), 64'd0);
    check("redir.valid", 64'(bus.inst_valid), 64'd0);
    step();
    check_head("redir.t0", 12'h040);
    check("redir.pc4", 64'(bus.inst_pc_plus4), 64'h044);
    step();
    check_head("redir.t1", 12'h044);
    step();
    check_head("redir.t2", 12'h048);

    // Misaligned target and address wrap
    redirect    = 1'b1;
    redirect_pc = 12'h043;
    #1;
    check("mis.iaddr", 64'(bus.iaddr), 64'h10);
    step();
    redirect = 1'b0;
    step();
    check_head("mis.head", 12'h040);
    redirect    = 1'b1;
    redirect_pc = 12'hFFC;
    #1;
    check("wrap.iaddr", 64'(bus.iaddr), 64'h3FF);
    step();
    redirect = 1'b0;
    step();
    check_head("wrap.top", 12'hFFC);
    check("wrap.pc4", 64'(bus.inst_pc_plus4), 64'h000);
    step();
    check_head("wrap.zero", 12'h000);
    step();
    check_head("wrap.four", 12'h004);

    // CLEAR beats redirect
    CLEAR       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 12'h080;
    #1;
    check("clr.iaddr", 64'(bus.iaddr), 64'h0);
    step();
    CLEAR    = 1'b0;
    redirect = 1'b0;
    step();
    check_head("clr.h0", 12'h000);
    step();
    check_head("clr.h1", 12'h004);

    // Asynchronous reset mid-stream
    RESET_N = 1'b0;
    #1;
    check("mrst.valid", 64'(bus.inst_valid), 64'd0);
    check("mrst.count", 64'(count), 64'd0);
    check("mrst.inst", 64'(bus.inst), 64'd0);
    check("mrst.pc", 64'(bus.inst_pc), 64'd0);
    check("mrst.pc4", 64'(bus.inst_pc_plus4), 64'd0);
    step();
    RESET_N = 1'b1;
    step();
    step();
    check_head("mrst.h0", 12'h000);

    // Random back-pressure: every pc in order exactly once
    exp_pc = 12'h000;
    for (int c = 0; c < 300; c++) begin
      check("rnd.count_max", 64'(count <= 3'd4), 64'd1);
      rdy            = 1'($urandom_range(0, 1));
      bus.inst_ready = rdy;
      if (bus.inst_valid && rdy) begin
        check("rnd.pc", 64'(bus.inst_pc), 64'(exp_pc));
        check("rnd.inst", 64'(bus.inst), 64'(exp_pc[11:2]));
        exp_pc = exp_pc + 12'd4;
        n_pops++;
      end
      step();
    end
    check("rnd.progress", 64'(n_pops >= 60), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
